// File: rtl/alu_mul_sequencer_pkg.sv
// alu_mul_sequencer_pkg: ALU control codes, datapath width and sequencer state encoding
package alu_mul_sequencer_pkg;
  localparam int XLEN = 64;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add multiplier (low XLEN bits) that borrows the shared ALU adder via req/gnt
// ports: clk/reset (async, active-high); in_valid/in_ready/in_a/in_b operand handshake;
// out_valid/out_ready/out_result result handshake; alu_req/alu_gnt arbitration;
// alu_rs1/alu_rs2/alu_ctrl drive the ALU, alu_out is its combinational sum
module alu_mul_sequencer #(
  parameter int XLEN = alu_mul_sequencer_pkg::XLEN,
  parameter int CNT_W = 7,
  parameter logic [3:0] ALU_ADD = alu_mul_sequencer_pkg::ALU_ADD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_out
);
  import alu_mul_sequencer_pkg::*;
  state_t r_state;
  logic [XLEN-1:0] r_acc, r_mcand, r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic w_step;
  assign w_step = r_state == RUN && alu_gnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_acc    <= '0;
        r_mcand  <= in_a;
        r_mplier <= in_b;
        r_cnt    <= '0;
        r_state  <= RUN;
      end
      if (w_step) begin
        r_acc    <= r_mplier[0] ? alu_out : r_acc;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(XLEN - 1)) r_state <= DONE;
      end
      if (r_state == DONE && out_ready) r_state <= IDLE;
    end
  assign in_ready   = r_state == IDLE;
  assign out_valid  = r_state == DONE;
  assign alu_req    = r_state == RUN;
  assign out_result = r_acc;
  assign alu_rs1    = r_acc;
  assign alu_rs2    = r_mcand;
  assign alu_ctrl   = ALU_ADD;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed vector table plus reset-mid-run sequence for alu_mul_sequencer
module tb_alu_mul_sequencer;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, alu_req, alu_gnt = 1;
  logic [63:0] in_a = 0, in_b = 0, out_result, alu_rs1, alu_rs2, alu_out;
  logic [3:0] alu_ctrl;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [63:0] a, b, exp;
    int nstall, lat, hold;
    string name;
  } vec_t;
  vec_t v[7];
  always #5 clk = ~clk;
  assign alu_out = alu_rs1 + alu_rs2;
  alu_mul_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_ctrl(alu_ctrl), .alu_out(alu_out)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // called at a negedge with the sequencer idle; returns at the negedge after the result handshake
  task automatic do_op(input vec_t t);
    logic [63:0] m_acc, m_mc, m_mp;
    int lat, reqs, stalls;
    logic ctrl_ok, rs_ok;
    chk({t.name, " in_ready before accept"}, 64'(in_ready), 64'd1);
    in_valid = 1; in_a = t.a; in_b = t.b;
    @(posedge clk); #1 in_valid = 0;
    m_acc = 0; m_mc = t.a; m_mp = t.b;
    lat = 0; reqs = 0; stalls = 0; ctrl_ok = 1; rs_ok = 1;
    while (1) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (lat > 300) begin
        chk({t.name, " timeout waiting out_valid"}, 64'(lat), 64'(t.lat));
        break;
      end
      if (alu_req) begin
        reqs++;
        if (alu_ctrl !== 4'b0010) ctrl_ok = 0;
        if (alu_rs1 !== m_acc || alu_rs2 !== m_mc) rs_ok = 0;
        if (stalls < t.nstall && lat % 7 == 3) begin
          alu_gnt = 0;
          stalls++;
        end else begin
          alu_gnt = 1;
          if (m_mp[0]) m_acc = m_acc + m_mc;
          m_mc = m_mc << 1;
          m_mp = m_mp >> 1;
        end
      end
      if (in_ready) rs_ok = 0;
    end
    alu_gnt = 1;
    chk({t.name, " latency"}, 64'(lat), 64'(t.lat));
    chk({t.name, " result"}, out_result, t.exp);
    chk({t.name, " alu_req cycles"}, 64'(reqs), 64'(64 + t.nstall));
    chk({t.name, " alu_ctrl ADD"}, 64'(ctrl_ok), 64'd1);
    chk({t.name, " rs1/rs2 track and hold"}, 64'(rs_ok), 64'd1);
    for (int k = 0; k < t.hold; k++) begin
      in_valid = 1; in_a = 64'hDEAD; in_b = 64'hBEEF;
      @(negedge clk);
      chk({t.name, " hold out_valid"}, 64'(out_valid), 64'd1);
      chk({t.name, " hold result"}, out_result, t.exp);
      chk({t.name, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    chk({t.name, " in_ready after handshake"}, 64'(in_ready), 64'd1);
    chk({t.name, " out_valid after handshake"}, 64'(out_valid), 64'd0);
  endtask
  initial begin
    v[0] = '{64'd7, 64'd6, 64'd42, 0, 65, 0, "7x6"};
    v[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 0, 65, 0, "-1x3"};
    v[2] = '{64'h8000_0000_0000_0000, 64'd2, 64'd0, 0, 65, 0, "2^63x2"};
    v[3] = '{64'd123456789, 64'd987654321, 64'd121932631112635269, 10, 75, 0, "stalls"};
    v[4] = '{64'd9, 64'd11, 64'd99, 0, 65, 5, "backpressure"};
    v[5] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 65, 0, "0xmax"};
    v[6] = '{64'd3, 64'd4, 64'd12, 0, 65, 0, "3x4 back-to-back"};
    #2;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset alu_req", 64'(alu_req), 64'd0);
    chk("reset out_result", out_result, 64'd0);
    chk("reset alu_rs1", alu_rs1, 64'd0);
    chk("reset alu_rs2", alu_rs2, 64'd0);
    chk("reset alu_ctrl", 64'(alu_ctrl), 64'd2);
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) do_op(v[i]);
    in_valid = 1; in_a = 64'd1000; in_b = 64'd1000;
    @(posedge clk); #1 in_valid = 0;
    repeat (30) @(negedge clk);
    chk("pre-reset alu_req", 64'(alu_req), 64'd1);
    reset = 1;
    #1;
    chk("mid-run reset alu_req", 64'(alu_req), 64'd0);
    chk("mid-run reset in_ready", 64'(in_ready), 64'd1);
    chk("mid-run reset out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 0;
    do_op('{64'd5, 64'd5, 64'd25, 0, 65, 0, "5x5 after reset"});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes the low XLEN bits of A*B by shift-and-add.
- It does not contain its own adder. It time-shares the existing 64-bit ALU, issuing one ADD (ALUcontrol 4'b0010) per iteration.
- It sits beside the ALU in the execute stage and requests the ALU through an external req/gnt arbiter.
- Operands arrive and results leave on valid/ready handshakes.

Parameters:
- XLEN, 64, operand/result width; must match ALU width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.
- ALU_ADD, 4'b0010, ALUcontrol code driven for every iteration.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; all state cleared immediately
- in_valid  in  1  operands present
- in_ready  out  1  sequencer can accept operands
- in_a  in  XLEN  multiplicand
- in_b  in  XLEN  multiplier
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  low XLEN bits of in_a*in_b
- alu_req  out  1  request ALU for this cycle
- alu_gnt  in  1  ALU granted this cycle
- alu_rs1  out  XLEN  to ALU rs1 (accumulator)
- alu_rs2  out  XLEN  to ALU rs2 (shifted multiplicand)
- alu_ctrl  out  4  to ALUcontrol
- alu_out  in  XLEN  ALU result, combinational in same cycle

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high; clock is clk, reset is reset.
- Reset values:
  - state=IDLE; acc, mcand, mplier, cnt = 0.
  - Outputs: in_ready=1, out_valid=0, alu_req=0, out_result=0, alu_rs1=0, alu_rs2=0, alu_ctrl=ALU_ADD.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready: acc<=0, mcand<=in_a, mplier<=in_b, cnt<=0, go to RUN.
  - RUN: alu_req=1, alu_rs1=acc, alu_rs2=mcand, alu_ctrl=ALU_ADD.
    - If alu_gnt=1, one iteration executes:
      - acc<=alu_out if mplier[0] else acc unchanged.
      - mcand<=mcand<<1 (MSB dropped); mplier<=mplier>>1 (logical); cnt<=cnt+1.
      - If cnt==XLEN-1, go to DONE.
    - If alu_gnt=0 (stall): all registers hold; alu_req stays 1.
  - DONE: out_valid=1, out_result=acc. On out_ready, go to IDLE. Without out_ready, out_result is held stable.
- Outside RUN: alu_req=0. alu_rs1/rs2 are don't-care but are driven to acc/mcand.
- Latency with continuous grant:
  - Accept on edge ending cycle T.
  - RUN during T+1..T+XLEN.
  - out_valid first high in T+XLEN+1 (cycle 65 for XLEN=64).
  - Each stall cycle adds exactly one cycle.
- Throughput: at most one operation in flight. in_ready=0 in RUN and DONE. No same-cycle bypass from DONE to accept; next accept is earliest the cycle after the result handshake.
- Arithmetic: result is modulo 2^XLEN, so it is identical for signed and unsigned operands (RISC-V MUL semantics). Overflow is silently discarded.
- No early termination: zero operands still take XLEN iterations.
- The ALU zero flag is ignored.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE; any partial result is lost; alu_req drops asynchronously.
- in_valid in RUN/DONE is ignored (not captured).
- alu_gnt while not requesting has no effect.

Decomposition:
- Shared package: ALU control codes (ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_AND=4'b0000, ALU_OR=4'b0001), XLEN, and the state enum {IDLE, RUN, DONE}.
- No sub-module: one FSM plus datapath registers in a single module. The adder is reached only through the alu_* ports.

Test Plan:
- Basic: in_a=7, in_b=6, gnt tied 1 → out_valid first in cycle 65 after accept; out_result=42; exactly 64 alu_req cycles, all with alu_ctrl=4'b0010.
- Wrap and sign:
  - in_a=64'hFFFF_FFFF_FFFF_FFFF (-1), in_b=3 → out_result=64'hFFFF_FFFF_FFFF_FFFD.
  - in_a=2^63, in_b=2 → 0.
- Stalls: in_a=123456789, in_b=987654321, alu_gnt low on 10 pseudo-random RUN cycles → result 121932631112635269, out_valid in cycle 75. Registers and alu_rs1/rs2 are unchanged across each stall.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid and out_result stable; in_ready=0; new in_valid ignored.
  - After the handshake, in_ready=1 in the next cycle.
- Reset mid-RUN: assert reset at iteration 30 → in the same cycle alu_req=0, in_ready=1, out_valid=0. A following operation 5*5 returns 25 with normal latency.
- Zero and back-to-back:
  - 0*(2^64-1) → 0 after 64 iterations.
  - Immediately following 3*4 → 12; accept occurs one cycle after the prior result handshake.
